puf_sequencer: RTL and testbench
================================

# puf_sequencer

Control FSM for the RO-based PUF response path. It applies a challenge by selecting ring-oscillator pairs one at a time, clears the race arbiter, and enables the rings. It waits for the arbiter's `finish` or a timeout, then shifts each winner bit into an N-bit response word. It sits between the top-level challenge/response interface and the RO bank plus arbiter.

## Interface
Parameters:
- `N_BITS`, 8: response width; one race per bit.
- `SEL_W`, 4: width of the RO-pair select bus (2^SEL_W pairs).
- `SETTLE`, 4: idle cycles after pair select before enabling the rings (≥1).
- `TIMEOUT`, 255: maximum RACE cycles per bit (≥1).

Ports:
- `clk`, in, 1: sole clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: level-sampled request to begin a measurement; ignored unless IDLE.
- `challenge`, in, SEL_W: base pair index, captured on accepted `start`.
- `arb_resp`, in, 1: arbiter winner bit (1 = ring 1 won).
- `arb_finish`, in, 1: arbiter has latched a winner.
- `pair_sel`, out, SEL_W: RO pair selected for the current bit.
- `ro_en`, out, 1: enables the selected rings.
- `arb_rst`, out, 1: synchronous clear to the arbiter.
- `busy`, out, 1: high in every state except IDLE.
- `response`, out, N_BITS: assembled response; held stable outside a run.
- `valid`, out, 1: one-cycle pulse when `response` is complete.
- `timeout_err`, out, 1: sticky; set if any bit of the run timed out.

## Operation
- States: IDLE, CLEAR, SETTLE, RACE, CAPTURE, DONE.
- Reset values:
  - State is IDLE.
  - `pair_sel`, `response`, bit index, timers and `timeout_err` are 0.
  - `ro_en`, `valid` and `busy` are 0.
  - `arb_rst` is 1.
- IDLE, `start`=1:
  - Latch `challenge`, set bit index `i`=0, clear `timeout_err`.
  - Clear `response` to 0, then go to CLEAR.
- CLEAR, 1 cycle:
  - `arb_rst`=1, `ro_en`=0.
  - `pair_sel` = latched challenge XOR `i[SEL_W-1:0]`; the index wraps modulo 2^SEL_W.
  - Go to SETTLE.
- SETTLE, exactly `SETTLE` cycles: `arb_rst`=0, `ro_en`=0, down-counter running. Go to RACE.
- RACE:
  - `ro_en`=1 and the timer counts up.
  - `arb_finish`=1 moves to CAPTURE with bit = `arb_resp`.
  - If the timer reaches `TIMEOUT` without finish, move to CAPTURE with bit = 0 and set `timeout_err`.
  - Finish and timeout in the same cycle: finish wins, `timeout_err` is not set.
- CAPTURE, 1 cycle:
  - `ro_en`=0, `response[i]` ← bit.
  - If `i`==N_BITS-1, go to DONE; else `i`+1 and go to CLEAR.
- DONE, 1 cycle: `valid`=1, then go to IDLE.
- `arb_rst` is 1 in IDLE, CLEAR and DONE, and 0 elsewhere.
- `start` while busy is ignored; it is not queued.
- `rst_n` asserted mid-run aborts immediately to reset values. There is no `valid` for the partial run.
- Timer width: clog2(TIMEOUT+1); bit-index width: clog2(N_BITS).

## Timing
- All outputs are registered.
- `start` is sampled at edge 0, and `busy`=1 from the next cycle.
- Per bit: 1 (CLEAR) + SETTLE + k (RACE) + 1 (CAPTURE) cycles.
  - k is the number of RACE cycles up to and including the one where `arb_finish` is seen (1 ≤ k ≤ TIMEOUT).
- Whole run: N_BITS·(2+SETTLE) + Σk, plus 1 DONE cycle, plus the 1 IDLE→CLEAR acceptance cycle.
- `valid` and the final `response` appear together. `busy` drops in the cycle after `valid`.
- A new `start` can be accepted in the first IDLE cycle after DONE.

## Structure
- Shared package `puf_pkg`:
  - State enum `puf_seq_state_t`.
  - Default constants `PUF_N_BITS`, `PUF_SEL_W`, `PUF_SETTLE`, `PUF_TIMEOUT`.
- One natural sub-module, `puf_timer`: a loadable down/up counter with a terminal-count flag, reused for SETTLE and RACE.
- Everything else lives in `puf_sequencer`.

## Test plan
- N_BITS=8, SETTLE=4, `challenge`=4'h3, arbiter model finishes after 5 RACE cycles with `arb_resp` alternating 1,0,…:
  - `pair_sel` steps 3,2,1,0,7,6,5,4.
  - `response`=8'h55 and `valid` arrive on cycle 1 + 8·(2+4+5) + 1 = 90 after `start`.
  - `timeout_err`=0.
- Arbiter never finishes on bit 2, TIMEOUT=255: that bit's RACE lasts exactly 255 cycles, `response[2]`=0, `timeout_err`=1.
  - A following `start` clears `timeout_err`.
- `arb_finish`=1 on exactly the 255th RACE cycle with `arb_resp`=1: captured bit is 1 and `timeout_err`=0.
- `start` pulsed during RACE of bit 3: no effect. Exactly one `valid`, and `challenge` changes mid-run do not alter `pair_sel`.
- `rst_n` low during SETTLE of bit 5:
  - Asynchronously `ro_en`=0, `busy`=0, `arb_rst`=1, `response`=0.
  - No `valid`; the next `start` runs a clean 8-bit measurement.
- `challenge`=4'hF with N_BITS=16: `pair_sel` visits all 16 pairs exactly once (F down to 0) and wraps without error.

Source files
------------

// File: rtl/puf_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | puf_pkg : shared types and default parameters for the PUF response path  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package puf_pkg;

  localparam int PUF_N_BITS  = 8;
  localparam int PUF_SEL_W   = 4;
  localparam int PUF_SETTLE  = 4;
  localparam int PUF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    PUF_ST_IDLE    = 3'd0,
    PUF_ST_CLEAR   = 3'd1,
    PUF_ST_SETTLE  = 3'd2,
    PUF_ST_RACE    = 3'd3,
    PUF_ST_CAPTURE = 3'd4,
    PUF_ST_DONE    = 3'd5
  } puf_seq_state_t;

  function automatic int puf_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/puf_timer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | puf_timer : loadable up/down counter with terminal-count compare         |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module puf_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  input  logic         up,
  input  logic [W-1:0] term_val,
  output logic         tc
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= load_val;
    end else if (en) begin
      r_count <= up ? (r_count + W'(1)) : (r_count - W'(1));
    end
  end

  assign tc = (r_count == term_val);

endmodule
`default_nettype wire

// File: rtl/puf_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | puf_sequencer : challenge -> RO pair race sequencing -> N-bit response   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module puf_sequencer
  import puf_pkg::*;
#(
  parameter int N_BITS  = PUF_N_BITS,
  parameter int SEL_W   = PUF_SEL_W,
  parameter int SETTLE  = PUF_SETTLE,
  parameter int TIMEOUT = PUF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [SEL_W-1:0]  challenge,
  input  logic              arb_resp,
  input  logic              arb_finish,
  output logic [SEL_W-1:0]  pair_sel,
  output logic              ro_en,
  output logic              arb_rst,
  output logic              busy,
  output logic [N_BITS-1:0] response,
  output logic              valid,
  output logic              timeout_err
);

  localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int TMR_W = puf_max($clog2(TIMEOUT + 1), $clog2(SETTLE + 1));

  localparam logic [2:0] S_IDLE    = PUF_ST_IDLE;
  localparam logic [2:0] S_CLEAR   = PUF_ST_CLEAR;
  localparam logic [2:0] S_SETTLE  = PUF_ST_SETTLE;
  localparam logic [2:0] S_RACE    = PUF_ST_RACE;
  localparam logic [2:0] S_CAPTURE = PUF_ST_CAPTURE;
  localparam logic [2:0] S_DONE    = PUF_ST_DONE;

  logic [2:0]        r_state;
  logic [SEL_W-1:0]  r_chal;
  logic [IDX_W-1:0]  r_idx;
  logic [SEL_W-1:0]  r_pair_sel;
  logic              r_ro_en;
  logic              r_arb_rst;
  logic              r_busy;
  logic [N_BITS-1:0] r_response;
  logic              r_valid;
  logic              r_timeout_err;

  logic [IDX_W-1:0]  w_idx_inc;
  logic [SEL_W-1:0]  w_sel_next;
  logic              w_last_bit;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_load_val;
  logic              w_tmr_en;
  logic              w_tmr_up;
  logic [TMR_W-1:0]  w_tmr_term;
  logic              w_tmr_tc;

  assign w_idx_inc  = r_idx + IDX_W'(1);
  // Pair index wraps naturally by truncating the bit index to the select width
  assign w_sel_next = r_chal ^ SEL_W'(w_idx_inc);
  assign w_last_bit = (r_idx == IDX_W'(N_BITS - 1));

  // SETTLE counts down to 1; RACE counts up from 1 so the count equals cycles spent
  always_comb begin
    w_tmr_load     = 1'b0;
    w_tmr_load_val = '0;
    w_tmr_en       = 1'b0;
    w_tmr_up       = 1'b0;
    w_tmr_term     = TMR_W'(1);
    case (r_state)
      S_CLEAR: begin
        w_tmr_load     = 1'b1;
        w_tmr_load_val = TMR_W'(SETTLE);
      end
      S_SETTLE: begin
        if (w_tmr_tc) begin
          w_tmr_load     = 1'b1;
          w_tmr_load_val = TMR_W'(1);
        end else begin
          w_tmr_en = 1'b1;
        end
      end
      S_RACE: begin
        w_tmr_en   = 1'b1;
        w_tmr_up   = 1'b1;
        w_tmr_term = TMR_W'(TIMEOUT);
      end
      default: begin
        w_tmr_load = 1'b0;
      end
    endcase
  end

  puf_timer #(
    .W (TMR_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (w_tmr_load),
    .load_val (w_tmr_load_val),
    .en       (w_tmr_en),
    .up       (w_tmr_up),
    .term_val (w_tmr_term),
    .tc       (w_tmr_tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_chal        <= '0;
      r_idx         <= '0;
      r_pair_sel    <= '0;
      r_ro_en       <= 1'b0;
      r_arb_rst     <= 1'b1;
      r_busy        <= 1'b0;
      r_response    <= '0;
      r_valid       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_chal        <= challenge;
            r_idx         <= '0;
            r_pair_sel    <= challenge;
            r_timeout_err <= 1'b0;
            r_response    <= '0;
            r_busy        <= 1'b1;
            r_arb_rst     <= 1'b1;
            r_state       <= S_CLEAR;
          end
        end
        S_CLEAR: begin
          r_arb_rst <= 1'b0;
          r_state   <= S_SETTLE;
        end
        S_SETTLE: begin
          if (w_tmr_tc) begin
            r_ro_en <= 1'b1;
            r_state <= S_RACE;
          end
        end
        S_RACE: begin
          // A finish seen on the timeout cycle still counts as a real result
          if (arb_finish) begin
            r_response[r_idx] <= arb_resp;
            r_ro_en           <= 1'b0;
            r_state           <= S_CAPTURE;
          end else if (w_tmr_tc) begin
            r_response[r_idx] <= 1'b0;
            r_timeout_err     <= 1'b1;
            r_ro_en           <= 1'b0;
            r_state           <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_arb_rst <= 1'b1;
          if (w_last_bit) begin
            r_valid <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_idx      <= w_idx_inc;
            r_pair_sel <= w_sel_next;
            r_state    <= S_CLEAR;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_ro_en   <= 1'b0;
          r_arb_rst <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  assign pair_sel    = r_pair_sel;
  assign ro_en       = r_ro_en;
  assign arb_rst     = r_arb_rst;
  assign busy        = r_busy;
  assign response    = r_response;
  assign valid       = r_valid;
  assign timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_puf_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_puf_sequencer : randomized bench for puf_sequencer (8- and 16-bit)    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_puf_sequencer;

  localparam int TMO    = 255;
  localparam int STL    = 4;
  localparam int BUDGET = 6000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  challenge;
  logic        arb_resp;
  logic        arb_finish;
  logic        use16;

  logic [3:0]  sel8, sel16;
  logic        ro8, ro16, ar8, ar16, busy8, busy16, val8, val16, te8, te16;
  logic [7:0]  resp8;
  logic [15:0] resp16;

  logic        start8, start16;
  logic [3:0]  m_sel;
  logic        m_ro_en, m_arb_rst, m_busy, m_valid, m_terr;
  logic [15:0] m_resp;

  assign start8    = start & ~use16;
  assign start16   = start & use16;
  assign m_sel     = use16 ? sel16  : sel8;
  assign m_ro_en   = use16 ? ro16   : ro8;
  assign m_arb_rst = use16 ? ar16   : ar8;
  assign m_busy    = use16 ? busy16 : busy8;
  assign m_valid   = use16 ? val16  : val8;
  assign m_terr    = use16 ? te16   : te8;
  assign m_resp    = use16 ? resp16 : {8'h00, resp8};

  puf_sequencer #(.N_BITS(8), .SEL_W(4), .SETTLE(STL), .TIMEOUT(TMO)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .challenge(challenge),
    .arb_resp(arb_resp), .arb_finish(arb_finish), .pair_sel(sel8), .ro_en(ro8),
    .arb_rst(ar8), .busy(busy8), .response(resp8), .valid(val8), .timeout_err(te8)
  );

  puf_sequencer #(.N_BITS(16), .SEL_W(4), .SETTLE(STL), .TIMEOUT(TMO)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16), .challenge(challenge),
    .arb_resp(arb_resp), .arb_finish(arb_finish), .pair_sel(sel16), .ro_en(ro16),
    .arb_rst(ar16), .busy(busy16), .response(resp16), .valid(val16), .timeout_err(te16)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // arbiter plan: plan_k = RACE cycle on which finish is shown (0 = never)
  int          plan_k [16];
  bit          plan_r [16];

  // reference expectations
  logic [3:0]  exp_sel [16];
  int          exp_len [16];
  logic [15:0] exp_resp;
  bit          exp_terr;
  int          exp_cyc;

  // observations
  logic [3:0]  obs_sel [16];
  int          obs_race [16];
  int          r_nvalid, r_cyc;
  logic [15:0] r_resp;
  logic        r_terr, r_terr_acc, r_busy_acc, r_busy_after, r_valid_after;
  logic        ab_ro_en, ab_busy, ab_arb_rst, ab_valid;
  logic [15:0] ab_resp;

  task automatic rand_plan(input int lo, input int hi);
    for (int b = 0; b < 16; b++) begin
      plan_k[b] = $urandom_range(hi, lo);
      plan_r[b] = 1'($urandom);
    end
  endtask

  task automatic model(input logic [3:0] chal, input int nb);
    exp_resp = '0;
    exp_terr = 1'b0;
    exp_cyc  = 2;
    for (int b = 0; b < nb; b++) begin
      if (plan_k[b] >= 1 && plan_k[b] <= TMO) begin
        exp_len[b]  = plan_k[b];
        exp_resp[b] = plan_r[b];
      end else begin
        exp_len[b]  = TMO;
        exp_terr    = 1'b1;
      end
      exp_sel[b] = chal ^ 4'(b);
      exp_cyc    = exp_cyc + 2 + STL + exp_len[b];
    end
  endtask

  // Starts a run at the current negedge; returns at the negedge after valid.
  task automatic run_meas(input logic [3:0] chal, input int glitch_bit, input int abort_bit);
    int  cyc, bi, race;
    bit  seen_clear, fin_run, fin;
    r_nvalid = 0; r_cyc = 0; r_resp = '0; r_terr = 1'b0;
    r_terr_acc = 1'bx; r_busy_acc = 1'bx; r_busy_after = 1'bx; r_valid_after = 1'bx;
    for (int b = 0; b < 16; b++) begin obs_sel[b] = '0; obs_race[b] = 0; end
    start = 1'b1; challenge = chal; arb_finish = 1'b0; arb_resp = 1'b0;
    cyc = 1; bi = 0; race = 0; seen_clear = 1'b0; fin_run = 1'b0;
    while (!fin_run) begin
      @(posedge clk); @(negedge clk);
      cyc++;
      start = 1'b0;
      challenge = 4'($urandom);
      if (cyc == 2) begin r_terr_acc = m_terr; r_busy_acc = m_busy; end
      if (cyc > BUDGET) begin
        n_tests++; n_fail++;
        $display("FAIL budget: no valid after %0d cycles", cyc);
        fin_run = 1'b1;
      end else if (m_valid) begin
        r_nvalid++; r_cyc = cyc; r_resp = m_resp; r_terr = m_terr;
        arb_finish = 1'b0;
        @(posedge clk); @(negedge clk);
        r_busy_after = m_busy; r_valid_after = m_valid;
        fin_run = 1'b1;
      end else if (m_ro_en) begin
        if (race == 0 && bi < 16) obs_sel[bi] = m_sel;
        race++;
        fin = (bi < 16) && (plan_k[bi] == race);
        arb_finish = fin;
        arb_resp   = fin ? plan_r[bi] : 1'($urandom);
        start      = (glitch_bit == bi);
        seen_clear = 1'b0;
      end else begin
        if (race != 0) begin
          if (bi < 16) obs_race[bi] = race;
          bi++; race = 0;
        end
        arb_finish = 1'($urandom);
        arb_resp   = 1'($urandom);
        if (m_arb_rst) begin
          seen_clear = 1'b1;
        end else if (seen_clear && m_busy && bi == abort_bit) begin
          arb_finish = 1'b0;
          rst_n = 1'b0;
          #1;
          ab_ro_en = m_ro_en; ab_busy = m_busy; ab_arb_rst = m_arb_rst;
          ab_resp = m_resp; ab_valid = m_valid;
          @(negedge clk);
          rst_n = 1'b1;
          repeat (12) begin
            @(negedge clk);
            if (m_valid) r_nvalid++;
          end
          fin_run = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; challenge = '0; arb_resp = 1'b0; arb_finish = 1'b0; use16 = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++; if (sel8 !== 4'h0) begin n_fail++; $display("FAIL reset_pair_sel: got %h want 0", sel8); end
    n_tests++; if (ro8 !== 1'b0) begin n_fail++; $display("FAIL reset_ro_en: got %b want 0", ro8); end
    n_tests++; if (ar8 !== 1'b1) begin n_fail++; $display("FAIL reset_arb_rst: got %b want 1", ar8); end
    n_tests++; if (busy8 !== 1'b0 || busy16 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b/%b want 0", busy8, busy16); end
    n_tests++; if (resp8 !== 8'h00 || resp16 !== 16'h0) begin n_fail++; $display("FAIL reset_response: got %h/%h want 0", resp8, resp16); end
    n_tests++; if (val8 !== 1'b0 || te8 !== 1'b0) begin n_fail++; $display("FAIL reset_valid_terr: got %b/%b want 0/0", val8, te8); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy8 !== 1'b0 || ar8 !== 1'b1) begin n_fail++; $display("FAIL idle_no_start: busy %b arb_rst %b want 0/1", busy8, ar8); end
  endtask

  task automatic test_directed();
    logic [3:0] seq [8] = '{4'h3, 4'h2, 4'h1, 4'h0, 4'h7, 4'h6, 4'h5, 4'h4};
    use16 = 1'b0;
    for (int b = 0; b < 16; b++) begin plan_k[b] = 5; plan_r[b] = (b % 2 == 0); end
    run_meas(4'h3, -1, -1);
    for (int b = 0; b < 8; b++) begin
      n_tests++; if (obs_sel[b] !== seq[b]) begin n_fail++; $display("FAIL dir_pair_sel[%0d]: got %h want %h", b, obs_sel[b], seq[b]); end
    end
    n_tests++; if (r_resp[7:0] !== 8'h55) begin n_fail++; $display("FAIL dir_response: got %h want 55", r_resp[7:0]); end
    n_tests++; if (r_cyc !== 90) begin n_fail++; $display("FAIL dir_latency: got %0d want 90", r_cyc); end
    n_tests++; if (r_terr !== 1'b0) begin n_fail++; $display("FAIL dir_timeout_err: got %b want 0", r_terr); end
    n_tests++; if (r_nvalid !== 1 || r_valid_after !== 1'b0) begin n_fail++; $display("FAIL dir_valid_pulse: count %0d after %b want 1/0", r_nvalid, r_valid_after); end
    n_tests++; if (r_busy_acc !== 1'b1 || r_busy_after !== 1'b0) begin n_fail++; $display("FAIL dir_busy: acc %b after %b want 1/0", r_busy_acc, r_busy_after); end
  endtask

  task automatic test_timeout();
    logic [3:0] chal;
    use16 = 1'b0;
    chal = 4'($urandom);
    rand_plan(1, 10);
    plan_k[2] = 0;
    model(chal, 8);
    run_meas(chal, -1, -1);
    n_tests++; if (obs_race[2] !== TMO) begin n_fail++; $display("FAIL tmo_race_len: got %0d want %0d", obs_race[2], TMO); end
    n_tests++; if (r_resp[2] !== 1'b0 || r_resp !== exp_resp) begin n_fail++; $display("FAIL tmo_response: got %h want %h", r_resp, exp_resp); end
    n_tests++; if (r_terr !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b want 1", r_terr); end
    n_tests++; if (r_cyc !== exp_cyc) begin n_fail++; $display("FAIL tmo_latency: got %0d want %0d", r_cyc, exp_cyc); end
    rand_plan(1, 8);
    model(chal, 8);
    run_meas(chal, -1, -1);
    n_tests++; if (r_terr_acc !== 1'b0 || r_terr !== 1'b0) begin n_fail++; $display("FAIL tmo_err_clear: acc %b end %b want 0/0", r_terr_acc, r_terr); end
  endtask

  task automatic test_edge_timeout();
    logic [3:0] chal;
    use16 = 1'b0;
    chal = 4'($urandom);
    rand_plan(1, 6);
    plan_k[4] = TMO; plan_r[4] = 1'b1;
    model(chal, 8);
    run_meas(chal, -1, -1);
    n_tests++; if (obs_race[4] !== TMO) begin n_fail++; $display("FAIL edge_race_len: got %0d want %0d", obs_race[4], TMO); end
    n_tests++; if (r_resp[4] !== 1'b1 || r_resp !== exp_resp) begin n_fail++; $display("FAIL edge_response: got %h want %h", r_resp, exp_resp); end
    n_tests++; if (r_terr !== 1'b0) begin n_fail++; $display("FAIL edge_err: got %b want 0", r_terr); end
  endtask

  task automatic test_start_ignored();
    logic [3:0] chal;
    int busy_cnt;
    use16 = 1'b0;
    chal = 4'($urandom);
    rand_plan(1, 9);
    model(chal, 8);
    run_meas(chal, 3, -1);
    for (int b = 0; b < 8; b++) begin
      n_tests++; if (obs_sel[b] !== exp_sel[b]) begin n_fail++; $display("FAIL ign_pair_sel[%0d]: got %h want %h", b, obs_sel[b], exp_sel[b]); end
    end
    n_tests++; if (r_resp !== exp_resp || r_cyc !== exp_cyc) begin n_fail++; $display("FAIL ign_result: resp %h cyc %0d want %h %0d", r_resp, r_cyc, exp_resp, exp_cyc); end
    busy_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (m_busy || m_valid) busy_cnt++;
    end
    n_tests++; if (r_nvalid !== 1 || busy_cnt !== 0) begin n_fail++; $display("FAIL ign_single_run: valids %0d extra busy %0d want 1/0", r_nvalid, busy_cnt); end
  endtask

  task automatic test_abort();
    logic [3:0] chal;
    use16 = 1'b0;
    chal = 4'($urandom);
    rand_plan(1, 7);
    run_meas(chal, -1, 5);
    n_tests++; if (ab_ro_en !== 1'b0 || ab_busy !== 1'b0 || ab_arb_rst !== 1'b1) begin n_fail++; $display("FAIL abort_ctl: ro_en %b busy %b arb_rst %b want 0 0 1", ab_ro_en, ab_busy, ab_arb_rst); end
    n_tests++; if (ab_resp !== 16'h0 || ab_valid !== 1'b0) begin n_fail++; $display("FAIL abort_resp: got %h valid %b want 0 0", ab_resp, ab_valid); end
    n_tests++; if (r_nvalid !== 0) begin n_fail++; $display("FAIL abort_no_valid: got %0d want 0", r_nvalid); end
    rand_plan(1, 7);
    model(chal, 8);
    run_meas(chal, -1, -1);
    n_tests++; if (r_resp !== exp_resp || r_cyc !== exp_cyc || r_nvalid !== 1) begin n_fail++; $display("FAIL abort_rerun: resp %h cyc %0d n %0d want %h %0d 1", r_resp, r_cyc, r_nvalid, exp_resp, exp_cyc); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] chal;
    use16 = 1'b0;
    for (int it = 0; it < 4; it++) begin
      chal = 4'($urandom);
      rand_plan(1, 12);
      for (int b = 0; b < 8; b++) begin
        if ($urandom_range(7, 0) == 0) plan_k[b] = 0;
        else if ($urandom_range(7, 0) == 0) plan_k[b] = TMO;
      end
      model(chal, 8);
      run_meas(chal, -1, -1);
      n_tests++; if (r_busy_acc !== 1'b1) begin n_fail++; $display("FAIL b2b_accept[%0d]: busy %b want 1", it, r_busy_acc); end
      n_tests++; if (r_resp !== exp_resp || r_terr !== exp_terr) begin n_fail++; $display("FAIL b2b_result[%0d]: resp %h terr %b want %h %b", it, r_resp, r_terr, exp_resp, exp_terr); end
      n_tests++; if (r_cyc !== exp_cyc) begin n_fail++; $display("FAIL b2b_latency[%0d]: got %0d want %0d", it, r_cyc, exp_cyc); end
      for (int b = 0; b < 8; b++) begin
        n_tests++; if (obs_race[b] !== exp_len[b]) begin n_fail++; $display("FAIL b2b_race[%0d][%0d]: got %0d want %0d", it, b, obs_race[b], exp_len[b]); end
      end
    end
  endtask

  task automatic test_wrap16();
    logic [15:0] seen;
    use16 = 1'b1;
    rand_plan(1, 4);
    model(4'hF, 16);
    run_meas(4'hF, -1, -1);
    seen = '0;
    for (int b = 0; b < 16; b++) begin
      seen[obs_sel[b]] = 1'b1;
      n_tests++; if (obs_sel[b] !== 4'(15 - b)) begin n_fail++; $display("FAIL wrap_pair_sel[%0d]: got %h want %h", b, obs_sel[b], 4'(15 - b)); end
    end
    n_tests++; if (seen !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_coverage: got %h want ffff", seen); end
    n_tests++; if (r_resp !== exp_resp || r_terr !== 1'b0 || r_nvalid !== 1) begin n_fail++; $display("FAIL wrap_result: resp %h terr %b n %0d want %h 0 1", r_resp, r_terr, r_nvalid, exp_resp); end
    use16 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_edge_timeout();
    test_start_ignored();
    test_abort();
    test_back_to_back();
    test_wrap16();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
